// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole round sequencer: RNG request, timed mole window, hit/miss judging, score keeping
module mole_round_ctrl #(
    parameter int NUM_HOLES  = 5,
    parameter int ROUNDS     = 30,
    parameter int SHOW_TICKS = 8,
    parameter int GAP_TICKS  = 4
) (
    input  logic                 clkGlobal,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 tick,
    input  logic [NUM_HOLES-1:0] btn,
    input  logic [2:0]           rnd_idx,
    output logic                 sample,
    output logic [NUM_HOLES-1:0] mole_led,
    output logic [2:0]           hole,
    output logic [5:0]           score,
    output logic [5:0]           misses,
    output logic [5:0]           round_cnt,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PICK = 3'd1,
        S_LOAD = 3'd2,
        S_SHOW = 3'd3,
        S_HIT  = 3'd4,
        S_MISS = 3'd5,
        S_GAP  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    localparam logic [7:0] SHOW_LOAD = 8'(SHOW_TICKS);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_TICKS);
    localparam logic [5:0] ROUNDS_W  = 6'(ROUNDS);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_HOLES-1:0] r_btn_q;
    logic [7:0]           r_timer;
    logic [2:0]           r_hole;
    logic [5:0]           r_score;
    logic [5:0]           r_misses;
    logic [5:0]           r_round_cnt;

    logic [NUM_HOLES-1:0] w_rise;
    logic [NUM_HOLES-1:0] w_hole_1h;
    logic                 w_wrong;
    logic                 w_right;
    logic                 w_timeout;
    logic                 w_gap_end;
    logic [2:0]           w_fold_idx;

    // Press detection and judging terms; a wrong bit anywhere in the edge vetoes a hit.
    assign w_rise     = btn & ~r_btn_q;
    assign w_hole_1h  = NUM_HOLES'(1) << r_hole;
    assign w_wrong    = |(w_rise & ~w_hole_1h);
    assign w_right    = (w_rise == w_hole_1h);
    assign w_timeout  = tick && (r_timer == 8'd1);
    assign w_gap_end  = tick && (r_timer == 8'd1);
    // RNG gives 0..7; indexes 5..7 wrap onto holes 0..2.
    assign w_fold_idx = (rnd_idx >= 3'd5) ? (rnd_idx - 3'd5) : rnd_idx;

    assign hole      = r_hole;
    assign score     = r_score;
    assign misses    = r_misses;
    assign round_cnt = r_round_cnt;

    // State register.
    always_ff @(posedge clkGlobal) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a press in the same cycle as the final tick is judged as a press.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_PICK;
                end
            end
            S_PICK: w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = S_SHOW;
            S_SHOW: begin
                if (w_wrong) begin
                    w_state_nxt = S_MISS;
                end else if (w_right) begin
                    w_state_nxt = S_HIT;
                end else if (w_timeout) begin
                    w_state_nxt = S_MISS;
                end
            end
            S_HIT, S_MISS: begin
                if (r_round_cnt == ROUNDS_W) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = S_PICK;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: button history, window timer, hole capture and game counters.
    always_ff @(posedge clkGlobal) begin
        if (reset) begin
            r_btn_q     <= '0;
            r_timer     <= '0;
            r_hole      <= '0;
            r_score     <= '0;
            r_misses    <= '0;
            r_round_cnt <= '0;
        end else begin
            r_btn_q <= btn;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_score     <= '0;
                        r_misses    <= '0;
                        r_round_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    r_hole  <= w_fold_idx;
                    r_timer <= SHOW_LOAD;
                end
                S_SHOW: begin
                    if (w_state_nxt == S_HIT) begin
                        r_score     <= r_score + 6'd1;
                        r_round_cnt <= r_round_cnt + 6'd1;
                    end else if (w_state_nxt == S_MISS) begin
                        r_misses    <= r_misses + 6'd1;
                        r_round_cnt <= r_round_cnt + 6'd1;
                    end else if (tick) begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                S_HIT, S_MISS: r_timer <= GAP_LOAD;
                S_GAP: begin
                    if (tick) begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        sample     = 1'b0;
        mole_led   = '0;
        hit_pulse  = 1'b0;
        miss_pulse = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (r_state)
            S_IDLE: busy = 1'b0;
            S_PICK: sample = 1'b1;
            S_SHOW: mole_led = w_hole_1h;
            S_HIT:  hit_pulse = 1'b1;
            S_MISS: miss_pulse = 1'b1;
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb/tb_mole_round_ctrl.sv - self-checking bench for mole_round_ctrl
module tb_mole_round_ctrl;

    localparam int SHOW_T = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic [4:0] btn = 5'b0;
    logic [2:0] rnd_idx = 3'd4;
    logic       sample;
    logic [4:0] mole_led;
    logic [2:0] hole;
    logic [5:0] score;
    logic [5:0] misses;
    logic [5:0] round_cnt;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       busy;
    logic       done;

    mole_round_ctrl dut (
        .clkGlobal (clk),
        .reset     (reset),
        .start     (start),
        .tick      (tick),
        .btn       (btn),
        .rnd_idx   (rnd_idx),
        .sample    (sample),
        .mole_led  (mole_led),
        .hole      (hole),
        .score     (score),
        .misses    (misses),
        .round_cnt (round_cnt),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] rnd;
        logic [4:0] mask;
        int         press_k;
        bit         with_tick;
        logic [2:0] exp_hole;
        logic [4:0] exp_led;
        bit         exp_hit;
    } vec_t;

    typedef struct {
        bit         hit;
        logic [5:0] score;
        logic [5:0] misses;
        logic [5:0] rounds;
    } sb_t;

    vec_t vecs[10];
    sb_t  sb[$];
    sb_t  mon_e;
    int   errors = 0;
    int   checks = 0;
    int   m_score = 0;
    int   m_misses = 0;
    int   m_rounds = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit hit);
        sb_t e;
        m_rounds++;
        if (hit) m_score++;
        else m_misses++;
        e.hit    = hit;
        e.score  = 6'(m_score);
        e.misses = 6'(m_misses);
        e.rounds = 6'(m_rounds);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (hit_pulse || miss_pulse) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'({hit_pulse, miss_pulse}), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("outcome_hit", 32'(hit_pulse), 32'(mon_e.hit));
                chk("outcome_miss", 32'(miss_pulse), 32'(!mon_e.hit));
                chk("score", 32'(score), 32'(mon_e.score));
                chk("misses", 32'(misses), 32'(mon_e.misses));
                chk("round_cnt", 32'(round_cnt), 32'(mon_e.rounds));
            end
        end
    end

    // Drive ticks through GAP until sample appears; a press mid-GAP must be ignored.
    task automatic wait_sample(output bit ok);
        ok = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (sample) begin
                ok = 1'b1;
                break;
            end
            btn = (i == 2) ? 5'b11111 : 5'b0;
            @(negedge clk);
        end
        tick = 1'b0;
        btn = 5'b0;
        if (!ok) chk("sample_timeout", 0, 1);
    endtask

    task automatic enter_show(input vec_t v, output bit ok);
        logic [2:0] junk;
        junk = (v.exp_hole == 3'd4) ? 3'd3 : 3'd4;
        wait_sample(ok);
        if (!ok) return;
        rnd_idx = junk;
        @(negedge clk);
        chk("sample_one_cycle", 32'(sample), 0);
        rnd_idx = v.rnd;
        @(negedge clk);
        rnd_idx = junk;
        chk("hole", 32'(hole), 32'(v.exp_hole));
        chk("mole_led", 32'(mole_led), 32'(v.exp_led));
        chk("busy_show", 32'(busy), 1);
    endtask

    task automatic play(input vec_t v);
        bit ok;
        bit fired;
        enter_show(v, ok);
        if (!ok) return;
        fired = 1'b0;
        for (int k = 0; k < SHOW_T && !fired; k++) begin
            tick = (k == v.press_k) ? v.with_tick : 1'b1;
            if (k == v.press_k || k == SHOW_T - 1) begin
                if (k == v.press_k) btn = v.mask;
                push(v.exp_hit);
                fired = 1'b1;
            end
            @(negedge clk);
            tick = 1'b0;
            btn = 5'b0;
            if (fired) begin
                chk("pulse_latency", 32'(hit_pulse | miss_pulse), 1);
                chk("led_off_judged", 32'(mole_led), 0);
            end else begin
                chk("led_held", 32'(mole_led), 32'(v.exp_led));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        //           rnd   mask      k  tick hole  led       hit
        vecs[0] = '{3'd2, 5'b00100, 0, 1'b0, 3'd2, 5'b00100, 1'b1};
        vecs[1] = '{3'd2, 5'b00000, 8, 1'b1, 3'd2, 5'b00100, 1'b0};
        vecs[2] = '{3'd2, 5'b00110, 3, 1'b1, 3'd2, 5'b00100, 1'b0};
        vecs[3] = '{3'd2, 5'b00100, 7, 1'b1, 3'd2, 5'b00100, 1'b1};
        vecs[4] = '{3'd6, 5'b00010, 2, 1'b0, 3'd1, 5'b00010, 1'b1};
        vecs[5] = '{3'd5, 5'b00001, 1, 1'b1, 3'd0, 5'b00001, 1'b1};
        vecs[6] = '{3'd7, 5'b00001, 4, 1'b0, 3'd2, 5'b00100, 1'b0};
        vecs[7] = '{3'd4, 5'b10000, 6, 1'b1, 3'd4, 5'b10000, 1'b1};
        vecs[8] = '{3'd3, 5'b00000, 8, 1'b1, 3'd3, 5'b01000, 1'b0};
        vecs[9] = '{3'd0, 5'b00001, 0, 1'b0, 3'd0, 5'b00001, 1'b1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_sample", 32'(sample), 0);
        chk("rst_led", 32'(mole_led), 0);
        chk("rst_hole", 32'(hole), 0);
        chk("rst_counters", 32'({score, misses, round_cnt}), 0);
        chk("rst_pulses", 32'({hit_pulse, miss_pulse}), 0);
        chk("rst_busy_done", 32'({busy, done}), 0);

        tick = 1'b1;
        repeat (4) @(negedge clk);
        tick = 1'b0;
        chk("idle_ignores_tick", 32'({busy, mole_led}), 0);

        // One scored round, then reset in the middle of the next SHOW window.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("sample_after_start", 32'(sample), 1);
        play(vecs[0]);
        enter_show(vecs[8], ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_led", 32'(mole_led), 32'(5'b01000));
        chk("start_ignored_busy", 32'({busy, sample}), 32'(2'b10));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_led", 32'(mole_led), 0);
        chk("midrst_counters", 32'({score, misses, round_cnt}), 0);
        m_score = 0;
        m_misses = 0;
        m_rounds = 0;
        @(negedge clk);

        // Full 30-round game cycling through the vector table.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("game_sample_after_start", 32'(sample), 1);
        for (int r = 0; r < 30; r++) begin
            play(vecs[r % 10]);
        end
        @(negedge clk);
        chk("end_done", 32'(done), 1);
        chk("end_busy", 32'(busy), 0);
        chk("end_score", 32'(score), 18);
        chk("end_misses", 32'(misses), 12);
        chk("end_rounds", 32'(round_cnt), 30);
        chk("end_led", 32'(mole_led), 0);

        tick = 1'b1;
        btn = 5'b11111;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        btn = 5'b0;
        chk("done_held", 32'({done, busy}), 32'(2'b10));
        chk("done_counters_held", 32'({score, misses, round_cnt}), 32'({6'd18, 6'd12, 6'd30}));

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_sample", 32'(sample), 1);
        chk("restart_cleared", 32'({score, misses, round_cnt}), 0);
        chk("restart_flags", 32'({done, busy}), 32'(2'b01));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("final_idle", 32'({busy, done}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
